// File: rtl/exc_encoder.sv
// -----------------------------------------------------------------------------
// exc_encoder
//
// Purpose:
//   Turns the raw per-lane exception flags of a dual-issue pipeline into the
//   one-hot control words CP0 consumes. It also sequences the pipeline
//   recovery: once an encoded exception has been registered, the block pulses
//   flush for one cycle. It then pulses redirect for one cycle with the target
//   PC, which is EPC for ERET and EXC_VECTOR for everything else.
//
// Handshake / timing:
//   Lanes are presented combinationally each cycle. When stall is low, the
//   encoded words, PCs, bad addresses and branch flag register with one cycle
//   of latency. When stall is high, those registers hold. The recovery FSM
//   leaves IDLE only when stall is low. Once it has left IDLE, it always
//   completes FLUSH -> REDIRECT -> IDLE in two cycles, whatever stall does.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   stall                       pipeline stall (holds output stage and IDLE)
//   valid_1/2, pc_1/2, ds_1/2   lane valid, PC, delay-slot flag (lane 1 older)
//   br_1                        lane-1 instruction is a branch/jump
//   raw_1/2                     raw exception flags, bit order:
//                               0 IF addr, 1 RI, 2 OV, 3 BREAK, 4 SYSCALL,
//                               5 load addr, 6 ERET, 7 store addr
//   vaddr_1/2                   memory virtual address per lane
//   epc_i                       current EPC from CP0
//   cp0_int_contr_word_1/2      {valid[15], 0, ds[9], 0, one-hot code[7:0]}
//   PC_1/2                      registered lane PC
//   orginalVritualAddrT_1/2     registered bad address (pc for IF addr error)
//   branch_1                    registered br_1 of an accepted lane 1
//   flush, redirect             recovery pulses (one cycle each)
//   redirect_pc                 redirect target, held outside REDIRECT
//   fsm_state                   debug view of the recovery FSM state
// -----------------------------------------------------------------------------
module exc_encoder #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        valid_1,
    input  logic        valid_2,
    input  logic [31:0] pc_1,
    input  logic [31:0] pc_2,
    input  logic        ds_1,
    input  logic        ds_2,
    input  logic        br_1,
    input  logic [7:0]  raw_1,
    input  logic [7:0]  raw_2,
    input  logic [31:0] vaddr_1,
    input  logic [31:0] vaddr_2,
    input  logic [31:0] epc_i,
    output logic [15:0] cp0_int_contr_word_1,
    output logic [15:0] cp0_int_contr_word_2,
    output logic [31:0] PC_1,
    output logic [31:0] PC_2,
    output logic [31:0] orginalVritualAddrT_1,
    output logic [31:0] orginalVritualAddrT_2,
    output logic        branch_1,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [7:0] CODE_ERET = 8'h40;

    state_t state_q;
    state_t state_d;

    logic        eret_q;

    logic [7:0]  code_1;
    logic [7:0]  code_2;
    logic        exc_pending;
    logic        accept;
    logic        take_1;
    logic        take_2;
    logic        kill_2;
    logic [15:0] word_1_d;
    logic [15:0] word_2_d;
    logic [31:0] bad_1_d;
    logic [31:0] bad_2_d;
    logic        branch_1_d;

    // Priority encoder: IF addr > RI > BREAK > SYSCALL > OV > load addr >
    // store addr. ERET sits last, so it wins only when it is the sole flag.
    function automatic logic [7:0] encode(input logic [7:0] raw);
        logic [7:0] code;
        code = 8'h00;
        if (raw[0])      code = 8'h01;
        else if (raw[1]) code = 8'h02;
        else if (raw[3]) code = 8'h08;
        else if (raw[4]) code = 8'h10;
        else if (raw[2]) code = 8'h04;
        else if (raw[5]) code = 8'h20;
        else if (raw[7]) code = 8'h80;
        else if (raw[6]) code = 8'h40;
        return code;
    endfunction

    // -------------------------------------------------------------------------
    // Lane encoding
    // -------------------------------------------------------------------------
    always_comb begin
        code_1      = encode(raw_1);
        code_2      = encode(raw_2);

        // A registered, non-zero word means an exception has been reported and
        // the FSM is about to leave IDLE. Younger instructions arriving in that
        // cycle are blocked, so CP0 never sees two reports for one recovery.
        exc_pending = (cp0_int_contr_word_1 != 16'h0000) ||
                      (cp0_int_contr_word_2 != 16'h0000);
        accept      = (state_q == ST_IDLE) && !exc_pending;

        take_1      = accept && valid_1 && (code_1 != 8'h00);

        // Lane 2 normally dies behind an older exception. When lane 1 is a
        // branch, lane 2 is its delay slot and survives, unless lane 1 is an
        // ERET.
        kill_2      = take_1 && (!br_1 || (code_1 == CODE_ERET));
        take_2      = accept && valid_2 && (code_2 != 8'h00) && !kill_2;

        word_1_d    = 16'h0000;
        word_2_d    = 16'h0000;
        if (take_1) word_1_d = {1'b1, 5'b00000, ds_1, 1'b0, code_1};
        if (take_2) word_2_d = {1'b1, 5'b00000, ds_2, 1'b0, code_2};

        // The IF address error faults on the fetch address itself.
        bad_1_d     = code_1[0] ? pc_1 : vaddr_1;
        bad_2_d     = code_2[0] ? pc_2 : vaddr_2;

        branch_1_d  = accept && valid_1 && br_1;
    end

    // -------------------------------------------------------------------------
    // Output stage
    // Lane-2 PC and bad address track the inputs even when lane 2 is killed.
    // Only its control word is zeroed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cp0_int_contr_word_1  <= 16'h0000;
            cp0_int_contr_word_2  <= 16'h0000;
            PC_1                  <= 32'h0000_0000;
            PC_2                  <= 32'h0000_0000;
            orginalVritualAddrT_1 <= 32'h0000_0000;
            orginalVritualAddrT_2 <= 32'h0000_0000;
            branch_1              <= 1'b0;
        end else if (!stall) begin
            cp0_int_contr_word_1  <= word_1_d;
            cp0_int_contr_word_2  <= word_2_d;
            PC_1                  <= pc_1;
            PC_2                  <= pc_2;
            orginalVritualAddrT_1 <= bad_1_d;
            orginalVritualAddrT_2 <= bad_2_d;
            branch_1              <= branch_1_d;
        end
    end

    // -------------------------------------------------------------------------
    // Recovery FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!stall && exc_pending) state_d = ST_FLUSH;
            end
            // FLUSH and REDIRECT ignore stall so recovery always completes.
            ST_FLUSH:    state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Remember whether the reported exception was an ERET. Lane 1 is older,
    // so its code decides whenever it reported one.
    always_ff @(posedge clk) begin
        if (reset) begin
            eret_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && (state_d == ST_FLUSH)) begin
            if (cp0_int_contr_word_1[7:0] != 8'h00) begin
                eret_q <= cp0_int_contr_word_1[6];
            end else begin
                eret_q <= cp0_int_contr_word_2[6];
            end
        end
    end

    // The target is captured while in FLUSH and becomes visible in REDIRECT.
    // It then holds until the next recovery.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_pc <= EXC_VECTOR;
        end else if (state_q == ST_FLUSH) begin
            redirect_pc <= eret_q ? epc_i : EXC_VECTOR;
        end
    end

    assign flush     = (state_q == ST_FLUSH);
    assign redirect  = (state_q == ST_REDIRECT);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_exc_encoder.sv
// -----------------------------------------------------------------------------
// tb_exc_encoder
//
// Directed bench for exc_encoder. Inputs change 1 ns after a rising edge, and
// outputs are sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_exc_encoder;

    localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        valid_1;
    logic        valid_2;
    logic [31:0] pc_1;
    logic [31:0] pc_2;
    logic        ds_1;
    logic        ds_2;
    logic        br_1;
    logic [7:0]  raw_1;
    logic [7:0]  raw_2;
    logic [31:0] vaddr_1;
    logic [31:0] vaddr_2;
    logic [31:0] epc_i;
    logic [15:0] word_1;
    logic [15:0] word_2;
    logic [31:0] pc_out_1;
    logic [31:0] pc_out_2;
    logic [31:0] bad_1;
    logic [31:0] bad_2;
    logic        branch_1;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] raw_tab  [8] = '{8'hFF, 8'h1A, 8'h18, 8'h34, 8'hA4, 8'hA0, 8'hC0, 8'h40};
    logic [7:0] code_tab [8] = '{8'h01, 8'h02, 8'h08, 8'h10, 8'h04, 8'h20, 8'h80, 8'h40};

    exc_encoder #(.EXC_VECTOR(EXC_VEC)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .stall                 (stall),
        .valid_1               (valid_1),
        .valid_2               (valid_2),
        .pc_1                  (pc_1),
        .pc_2                  (pc_2),
        .ds_1                  (ds_1),
        .ds_2                  (ds_2),
        .br_1                  (br_1),
        .raw_1                 (raw_1),
        .raw_2                 (raw_2),
        .vaddr_1               (vaddr_1),
        .vaddr_2               (vaddr_2),
        .epc_i                 (epc_i),
        .cp0_int_contr_word_1  (word_1),
        .cp0_int_contr_word_2  (word_2),
        .PC_1                  (pc_out_1),
        .PC_2                  (pc_out_2),
        .orginalVritualAddrT_1 (bad_1),
        .orginalVritualAddrT_2 (bad_2),
        .branch_1              (branch_1),
        .flush                 (flush),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .fsm_state             (fsm_state)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        valid_1 = 1'b0; valid_2 = 1'b0;
        pc_1    = 32'h0; pc_2    = 32'h0;
        ds_1    = 1'b0; ds_2    = 1'b0;
        br_1    = 1'b0;
        raw_1   = 8'h00; raw_2  = 8'h00;
        vaddr_1 = 32'h0; vaddr_2 = 32'h0;
    endtask

    // From the cycle where a word is visible, walk through FLUSH and REDIRECT
    // back to IDLE.
    task automatic drain();
        clear_lanes();
        repeat (3) tick();
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        clear_lanes();
        epc_i   = 32'h0;
        stall   = 1'b1;
        reset   = 1'b1;
        valid_1 = 1'b1; raw_1 = 8'h04; pc_1 = 32'h40;
        repeat (2) tick();
        n_checks++; if (word_1 !== 16'h0) begin n_fail++; $display("FAIL reset_word_1: got %h expected %h", word_1, 16'h0); end
        n_checks++; if (pc_out_1 !== 32'h0) begin n_fail++; $display("FAIL reset_pc_1: got %h expected %h", pc_out_1, 32'h0); end
        n_checks++; if (flush !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got flush %b redirect %b expected 0 0", flush, redirect); end
        n_checks++; if (redirect_pc !== EXC_VEC) begin n_fail++; $display("FAIL reset_redirect_pc: got %h expected %h", redirect_pc, EXC_VEC); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
        reset = 1'b0;
        stall = 1'b0;
        clear_lanes();
        tick();
    endtask

    task automatic test_ov_syscall();
        clear_lanes();
        valid_1 = 1'b1; raw_1 = 8'h14; pc_1 = 32'h100; vaddr_1 = 32'h55;
        tick();
        n_checks++; if (word_1 !== 16'h8010) begin n_fail++; $display("FAIL ovsys_word_1: got %h expected %h", word_1, 16'h8010); end
        n_checks++; if (pc_out_1 !== 32'h100) begin n_fail++; $display("FAIL ovsys_pc_1: got %h expected %h", pc_out_1, 32'h100); end
        n_checks++; if (bad_1 !== 32'h55) begin n_fail++; $display("FAIL ovsys_badaddr_1: got %h expected %h", bad_1, 32'h55); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL ovsys_flush_early: got %b expected 0", flush); end
        clear_lanes();
        tick();
        n_checks++; if (flush !== 1'b1 || redirect !== 1'b0) begin n_fail++; $display("FAIL ovsys_flush: got flush %b redirect %b expected 1 0", flush, redirect); end
        n_checks++; if (word_1 !== 16'h0) begin n_fail++; $display("FAIL ovsys_word_in_flush: got %h expected %h", word_1, 16'h0); end
        tick();
        n_checks++; if (redirect !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL ovsys_redirect: got flush %b redirect %b expected 0 1", flush, redirect); end
        n_checks++; if (redirect_pc !== EXC_VEC) begin n_fail++; $display("FAIL ovsys_redirect_pc: got %h expected %h", redirect_pc, EXC_VEC); end
        tick();
        n_checks++; if (redirect !== 1'b0 || fsm_state !== 2'd0) begin n_fail++; $display("FAIL ovsys_back_idle: got redirect %b state %0d expected 0 0", redirect, fsm_state); end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 8; i++) begin
            clear_lanes();
            valid_1 = 1'b1; raw_1 = raw_tab[i]; pc_1 = 32'h1000 + 32'(i * 4); vaddr_1 = 32'hA000;
            tick();
            n_checks++;
            if (word_1 !== {8'h80, code_tab[i]}) begin
                n_fail++;
                $display("FAIL priority_raw_%h: got %h expected %h", raw_tab[i], word_1, {8'h80, code_tab[i]});
            end
            drain();
        end
        // IF address error reports the PC as the bad address.
        clear_lanes();
        valid_1 = 1'b1; raw_1 = 8'h01; pc_1 = 32'h2224; vaddr_1 = 32'h9999;
        tick();
        n_checks++; if (bad_1 !== 32'h2224) begin n_fail++; $display("FAIL ifaddr_badaddr: got %h expected %h", bad_1, 32'h2224); end
        drain();
    endtask

    task automatic test_lane2_kill();
        clear_lanes();
        valid_1 = 1'b1; raw_1 = 8'h02; br_1 = 1'b0; pc_1 = 32'h200;
        valid_2 = 1'b1; raw_2 = 8'h04; pc_2 = 32'h204; vaddr_2 = 32'h7770;
        tick();
        n_checks++; if (word_1 !== 16'h8002) begin n_fail++; $display("FAIL kill_word_1: got %h expected %h", word_1, 16'h8002); end
        n_checks++; if (word_2 !== 16'h0) begin n_fail++; $display("FAIL kill_word_2: got %h expected %h", word_2, 16'h0); end
        n_checks++; if (pc_out_2 !== 32'h204) begin n_fail++; $display("FAIL kill_pc_2: got %h expected %h", pc_out_2, 32'h204); end
        n_checks++; if (bad_2 !== 32'h7770) begin n_fail++; $display("FAIL kill_badaddr_2: got %h expected %h", bad_2, 32'h7770); end
        drain();
    endtask

    task automatic test_delay_slot();
        clear_lanes();
        valid_1 = 1'b1; br_1 = 1'b1; pc_1 = 32'h300;
        valid_2 = 1'b1; raw_2 = 8'h80; ds_2 = 1'b1; pc_2 = 32'h304; vaddr_2 = 32'h1233;
        tick();
        n_checks++; if (word_1 !== 16'h0) begin n_fail++; $display("FAIL ds_word_1: got %h expected %h", word_1, 16'h0); end
        n_checks++; if (word_2 !== 16'h8280) begin n_fail++; $display("FAIL ds_word_2: got %h expected %h", word_2, 16'h8280); end
        n_checks++; if (bad_2 !== 32'h1233) begin n_fail++; $display("FAIL ds_badaddr_2: got %h expected %h", bad_2, 32'h1233); end
        n_checks++; if (branch_1 !== 1'b1) begin n_fail++; $display("FAIL ds_branch_1: got %b expected 1", branch_1); end
        drain();
        // The delay slot survives a non-ERET exception in its branch.
        clear_lanes();
        valid_1 = 1'b1; br_1 = 1'b1; raw_1 = 8'h02;
        valid_2 = 1'b1; raw_2 = 8'h80; ds_2 = 1'b1;
        tick();
        n_checks++; if (word_1 !== 16'h8002 || word_2 !== 16'h8280) begin n_fail++; $display("FAIL ds_both: got %h %h expected 8002 8280", word_1, word_2); end
        drain();
        // The delay slot dies behind an ERET in its branch.
        clear_lanes();
        valid_1 = 1'b1; br_1 = 1'b1; raw_1 = 8'h40;
        valid_2 = 1'b1; raw_2 = 8'h80; ds_2 = 1'b1;
        tick();
        n_checks++; if (word_1 !== 16'h8040 || word_2 !== 16'h0) begin n_fail++; $display("FAIL ds_eret_kill: got %h %h expected 8040 0000", word_1, word_2); end
        drain();
    endtask

    task automatic test_invalid();
        clear_lanes();
        valid_1 = 1'b0; raw_1 = 8'h04;
        valid_2 = 1'b0; raw_2 = 8'h08;
        tick();
        n_checks++; if (word_1 !== 16'h0 || word_2 !== 16'h0) begin n_fail++; $display("FAIL invalid_words: got %h %h expected 0000 0000", word_1, word_2); end
        tick();
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL invalid_flush: got %b expected 0", flush); end
        clear_lanes();
        tick();
    endtask

    task automatic test_eret();
        clear_lanes();
        epc_i   = 32'h8000_0200;
        valid_1 = 1'b1; raw_1 = 8'h40; pc_1 = 32'h600;
        tick();
        n_checks++; if (word_1 !== 16'h8040) begin n_fail++; $display("FAIL eret_word_1: got %h expected %h", word_1, 16'h8040); end
        clear_lanes();
        tick();
        tick();
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h8000_0200) begin n_fail++; $display("FAIL eret_redirect: got %b %h expected 1 80000200", redirect, redirect_pc); end
        tick();
        n_checks++; if (redirect_pc !== 32'h8000_0200) begin n_fail++; $display("FAIL eret_hold: got %h expected %h", redirect_pc, 32'h8000_0200); end
        // ERET reported by lane 2 alone.
        clear_lanes();
        epc_i   = 32'h8000_0300;
        valid_1 = 1'b1;
        valid_2 = 1'b1; raw_2 = 8'h40;
        tick();
        n_checks++; if (word_2 !== 16'h8040) begin n_fail++; $display("FAIL eret2_word_2: got %h expected %h", word_2, 16'h8040); end
        clear_lanes();
        tick();
        tick();
        n_checks++; if (redirect_pc !== 32'h8000_0300) begin n_fail++; $display("FAIL eret2_redirect_pc: got %h expected %h", redirect_pc, 32'h8000_0300); end
        tick();
        // An ordinary exception goes back to the vector.
        valid_1 = 1'b1; raw_1 = 8'h08;
        tick();
        clear_lanes();
        tick();
        tick();
        n_checks++; if (redirect_pc !== EXC_VEC) begin n_fail++; $display("FAIL post_eret_vector: got %h expected %h", redirect_pc, EXC_VEC); end
        tick();
    endtask

    task automatic test_stall();
        clear_lanes();
        stall   = 1'b1;
        valid_1 = 1'b1; raw_1 = 8'h04; pc_1 = 32'h400;
        tick();
        n_checks++; if (word_1 !== 16'h0) begin n_fail++; $display("FAIL stall_no_capture: got %h expected %h", word_1, 16'h0); end
        tick();
        n_checks++; if (flush !== 1'b0 || fsm_state !== 2'd0) begin n_fail++; $display("FAIL stall_no_transition: got flush %b state %0d expected 0 0", flush, fsm_state); end
        stall = 1'b0;
        tick();
        n_checks++; if (word_1 !== 16'h8004) begin n_fail++; $display("FAIL stall_release_word: got %h expected %h", word_1, 16'h8004); end
        stall = 1'b1;
        clear_lanes();
        repeat (2) tick();
        n_checks++; if (word_1 !== 16'h8004 || flush !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got word %h flush %b expected 8004 0", word_1, flush); end
        stall = 1'b0;
        tick();
        n_checks++; if (flush !== 1'b1 || word_1 !== 16'h0) begin n_fail++; $display("FAIL stall_flush: got flush %b word %h expected 1 0000", flush, word_1); end
        stall = 1'b1;
        tick();
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL stall_redirect_not_frozen: got %b expected 1", redirect); end
        tick();
        n_checks++; if (fsm_state !== 2'd0 || redirect !== 1'b0) begin n_fail++; $display("FAIL stall_back_idle: got state %0d redirect %b expected 0 0", fsm_state, redirect); end
        stall = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        clear_lanes();
        epc_i   = 32'h8000_0400;
        valid_1 = 1'b1; raw_1 = 8'h40;
        tick();
        clear_lanes();
        tick();
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL rstflush_in_flush: got %b expected 1", flush); end
        reset = 1'b1;
        tick();
        n_checks++; if (flush !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL rstflush_pulses: got flush %b redirect %b expected 0 0", flush, redirect); end
        n_checks++; if (word_1 !== 16'h0 || word_2 !== 16'h0) begin n_fail++; $display("FAIL rstflush_words: got %h %h expected 0000 0000", word_1, word_2); end
        n_checks++; if (redirect_pc !== EXC_VEC) begin n_fail++; $display("FAIL rstflush_redirect_pc: got %h expected %h", redirect_pc, EXC_VEC); end
        reset = 1'b0;
        tick();
        n_checks++; if (redirect !== 1'b0 || fsm_state !== 2'd0) begin n_fail++; $display("FAIL rstflush_no_redirect: got redirect %b state %0d expected 0 0", redirect, fsm_state); end
        // Reset wins over stall.
        valid_1 = 1'b1; raw_1 = 8'h20; pc_1 = 32'h700;
        tick();
        stall = 1'b1;
        reset = 1'b1;
        tick();
        n_checks++; if (word_1 !== 16'h0 || pc_out_1 !== 32'h0) begin n_fail++; $display("FAIL reset_over_stall: got word %h pc %h expected 0000 0", word_1, pc_out_1); end
        reset = 1'b0;
        stall = 1'b0;
        clear_lanes();
        tick();
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_ov_syscall();
        test_priority();
        test_lane2_kill();
        test_delay_slot();
        test_invalid();
        test_eret();
        test_stall();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
